// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit registered ALU with valid/ready on both sides.
// Single-cycle ops: AND, OR, NOR, ADD, SUB, SLT (overflow-safe signed compare).
// MULU: iterative shift-add unsigned multiply, one multiplier bit per cycle.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o   request handshake; op_i, a_i, b_i sampled on accept
//   out_valid_o/out_ready_i result handshake; result held until taken
//   result_o, hi_o      result (low product half for MULU), high product half
//   zero_o, carry_o, overflow_o  flags for the registered result
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MULU = 4'b1000;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;
   logic                ovf_q, ovf_d;
   logic [2*WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   // Shared adder: SUB and SLT use a + ~b + 1
   logic             sub;
   logic [WIDTH-1:0] b_op, sum;
   logic             add_c, add_v;
   logic [WIDTH-1:0] s_res;
   logic             s_c, s_v;

   always_comb begin
      sub          = (op_i == OP_SUB) || (op_i == OP_SLT);
      b_op         = sub ? ~b_i : b_i;
      {add_c, sum} = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
      add_v        = (a_i[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

      s_res = '0;
      s_c   = 1'b0;
      s_v   = 1'b0;
      unique case (op_i)
         OP_AND: s_res = a_i & b_i;
         OP_OR:  s_res = a_i | b_i;
         OP_NOR: s_res = ~(a_i | b_i);
         OP_ADD, OP_SUB: begin
            s_res = sum;
            s_c   = add_c;
            s_v   = add_v;
         end
         // sign of the true difference, corrected when the subtraction overflows
         OP_SLT: s_res[0] = sum[WIDTH-1] ^ add_v;
         default: s_res = '0;
      endcase
   end

   // One shift-add step: add multiplicand into the upper half when the
   // current multiplier LSB is set, then shift the whole accumulator right.
   logic [WIDTH:0]       mul_add;
   logic [2*WIDTH-1:0]   acc_step;

   always_comb begin
      mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step = {mul_add, acc_q[WIDTH-1:1]};
   end

   logic accept;

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      hi_d       = hi_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      ovf_d      = ovf_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      cnt_d      = cnt_q;
      in_ready_o = 1'b0;

      unique case (state_q)
         S_IDLE: in_ready_o = rst_n;
         S_MUL: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = S_DONE;
               result_d = acc_step[WIDTH-1:0];
               hi_d     = acc_step[2*WIDTH-1:WIDTH];
               zero_d   = (acc_step[WIDTH-1:0] == '0);
               carry_d  = 1'b0;
               ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
            end
         end
         S_DONE: begin
            in_ready_o = rst_n && out_ready_i;
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      accept = in_valid_i && in_ready_o;
      if (accept) begin
         if (op_i == OP_MULU) begin
            state_d = S_MUL;
            mcand_d = a_i;
            acc_d   = {{WIDTH{1'b0}}, b_i};
            cnt_d   = '0;
         end else begin
            state_d  = S_DONE;
            result_d = s_res;
            hi_d     = '0;
            zero_d   = (s_res == '0);
            carry_d  = s_c;
            ovf_d    = s_v;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign hi_o        = hi_q;
   assign zero_o      = zero_q;
   assign carry_o     = carry_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written handshake/reset sequences
// and randomized ops checked against an arithmetic reference model (WIDTH = 8).
module tb_alu_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   op = 4'b0000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result, hi;
   logic         zero, carry, overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .op_i       (op),
      .a_i        (a),
      .b_i        (b),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .result_o   (result),
      .hi_o       (hi),
      .zero_o     (zero),
      .carry_o    (carry),
      .overflow_o (overflow)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [7:0] hi;
      logic       z;
      logic       c;
      logic       v;
      int         lat;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic       z;
      logic       c;
      logic       v;
      int         lat;
   } obs_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_legal(input logic [3:0] o);
      return (o == 4'b0000) || (o == 4'b0001) || (o == 4'b0010) || (o == 4'b0110) ||
             (o == 4'b0111) || (o == 4'b1100) || (o == 4'b1000);
   endfunction

   // Reference model from the arithmetic definitions
   function automatic vec_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      vec_t e;
      int   ux, uy, sx, sy, s, p;
      ux = int'(x);
      uy = int'(y);
      sx = $signed(x);
      sy = $signed(y);
      e.op = o; e.a = x; e.b = y;
      e.res = 8'h00; e.hi = 8'h00; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
      case (o)
         4'b0000: e.res = x & y;
         4'b0001: e.res = x | y;
         4'b1100: e.res = ~(x | y);
         4'b0010: begin
            s     = ux + uy;
            e.res = s[7:0];
            e.c   = (s > 255);
            e.v   = ((sx + sy) > 127) || ((sx + sy) < -128);
         end
         4'b0110: begin
            s     = ux - uy;
            e.res = s[7:0];
            e.c   = (ux >= uy);
            e.v   = ((sx - sy) > 127) || ((sx - sy) < -128);
         end
         4'b0111: e.res = (sx < sy) ? 8'h01 : 8'h00;
         4'b1000: begin
            p     = ux * uy;
            e.res = p[7:0];
            e.hi  = p[15:8];
            e.v   = (p[15:8] != 8'h00);
            e.lat = W + 1;
         end
         default: e.res = 8'h00;
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   // Called at a negedge with the DUT idle or in DONE with out_ready high.
   // Returns at the negedge where out_valid was first seen.
   task automatic apply(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output obs_t r);
      int waitc;
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      waitc = 0;
      #1;
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk("accept_wait", waitc, 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      r.lat = 1;
      while (!out_valid && r.lat < 40) begin
         @(negedge clk);
         r.lat++;
      end
      r.res = result; r.hi = hi; r.z = zero; r.c = carry; r.v = overflow;
   endtask

   task automatic check_vec(input string tag, input vec_t e, input obs_t r);
      chk({tag, ".result"},   r.res, e.res);
      chk({tag, ".hi"},       r.hi,  e.hi);
      chk({tag, ".zero"},     r.z,   e.z);
      chk({tag, ".carry"},    r.c,   e.c);
      chk({tag, ".overflow"}, r.v,   e.v);
      chk({tag, ".latency"},  r.lat, e.lat);
   endtask

   vec_t tbl[14];
   logic [3:0] legal_ops[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};

   initial begin
      obs_t       r;
      vec_t       e;
      logic [3:0] ro;

      //            op       a      b      res    hi     z     c     v     lat
      tbl[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1};
      tbl[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
      tbl[2]  = '{4'b0111, 8'h80, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[3]  = '{4'b0111, 8'h7F, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
      tbl[4]  = '{4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 9};
      tbl[5]  = '{4'b0101, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
      tbl[6]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[7]  = '{4'b0001, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[8]  = '{4'b1100, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
      tbl[9]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
      tbl[10] = '{4'b0110, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[11] = '{4'b0110, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1};
      tbl[12] = '{4'b1000, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 9};
      tbl[13] = '{4'b1000, 8'h0F, 8'h0F, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0, 9};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.in_ready",  in_ready, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.result",    result, 0);
      chk("rst.hi",        hi, 0);
      chk("rst.flags",     {zero, carry, overflow}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.in_ready_after", in_ready, 1);

      // directed table
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].op, tbl[i].a, tbl[i].b, r);
         check_vec($sformatf("vec%0d", i), tbl[i], r);
      end
      @(negedge clk);

      // MULU stall: in_ready low for W cycles, result after W+1
      op = 4'b1000; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mul.in_ready_c%0d", i), in_ready, 0);
         chk($sformatf("mul.out_valid_c%0d", i), out_valid, 0);
         @(negedge clk);
      end
      chk("mul.out_valid", out_valid, 1);
      chk("mul.result", {hi, result}, 16'hFE01);
      @(negedge clk);

      // backpressure then same-cycle accept
      out_ready = 1'b0;
      op = 4'b0010; a = 8'h10; b = 8'h20; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp.out_valid_c%0d", i), out_valid, 1);
         chk($sformatf("bp.result_c%0d", i), result, 8'h30);
         chk($sformatf("bp.flags_c%0d", i), {zero, carry, overflow}, 3'b000);
         chk($sformatf("bp.in_ready_c%0d", i), in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      op = 4'b1100; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
      #1;
      chk("bp.in_ready_release", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.nor_valid", out_valid, 1);
      chk("bp.nor_result", result, 8'h00);
      chk("bp.nor_zero", zero, 1);
      @(negedge clk);
      chk("bp.drained", out_valid, 0);

      // reset four cycles into a MULU
      op = 4'b1000; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmul.out_valid", out_valid, 0);
      chk("rstmul.in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmul.in_ready_after", in_ready, 1);
      chk("rstmul.result_cleared", {hi, result}, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("rstmul.no_stale_c%0d", i), out_valid, 0);
         @(negedge clk);
      end
      apply(4'b0000, 8'hF0, 8'h3C, r);
      check_vec("rstmul.and", model(4'b0000, 8'hF0, 8'h3C), r);
      @(negedge clk);

      // reset while holding a result in DONE
      out_ready = 1'b0;
      op = 4'b0010; a = 8'h01; b = 8'h02; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rstdone.valid_before", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rstdone.out_valid", out_valid, 0);
      chk("rstdone.in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rstdone.no_stale", out_valid, 0);
      end

      // randomized ops against the reference model
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            ro = 4'($urandom);
            while (is_legal(ro)) ro = 4'($urandom);
         end else begin
            ro = legal_ops[$urandom_range(0, 6)];
         end
         e = model(ro, 8'($urandom), 8'($urandom));
         apply(e.op, e.a, e.b, r);
         check_vec($sformatf("rnd%0d_op%b", i, ro), e, r);
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised WIDTH-bit registered ALU for the datapath. It provides the bitwise and adder operations of the existing per-bit ALU cells, plus NOR and a signed set-less-than that remains correct on overflow. It adds an iterative unsigned multiply and carry/overflow/zero flags. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake, so the block sits between the register-read and writeback stages and can stall either side.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- op  in  4  operation select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULU; all other codes are illegal
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  result; low half of the product for MULU
- hi  out  WIDTH  high half of the product for MULU, 0 for all other ops
- zero  out  1  result == 0
- carry  out  1  adder carry-out (ADD/SUB only)
- overflow  out  1  signed overflow (ADD/SUB); hi != 0 (MULU)

## Operation
- States: IDLE, MUL, DONE.
- An operation is accepted when in_valid && in_ready. op, a and b are sampled on the accepting edge.
- in_ready = 1 in IDLE, and in DONE while out_ready is 1. In DONE that allows a back-to-back accept in the same cycle the current result is taken. in_ready = 0 in MUL and while rst_n is low.
- Single-cycle ops go to DONE on the accepting edge. Results and flags are registered there.
- Adder behaviour:
  - ADD: sum = a + b.
  - SUB: sum = a + ~b + 1, so carry = 1 means no borrow.
  - overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the post-invert operand.
- SLT: result = {0…, sum_msb ^ overflow} using the SUB adder; carry = 0 and overflow = 0 are reported.
- AND/OR/NOR: carry = 0, overflow = 0.
- Illegal op: result = 0, hi = 0, zero = 1, carry = 0, overflow = 0, same latency as ADD.
- MULU (IDLE → MUL):
  - Shift-add, one multiplier bit per cycle, WIDTH iterations, using a 2·WIDTH-bit accumulator and an iteration counter of $clog2(WIDTH)+1 bits.
  - After the last iteration, go to DONE with {hi, result} = a × b unsigned.
  - carry = 0, overflow = (hi != 0).
- zero always reflects the final registered result (low half only for MULU).
- DONE:
  - out_valid = 1. result, hi and flags are held stable until out_ready.
  - On out_ready: if a new request is accepted the same cycle, go to DONE or MUL; otherwise go to IDLE and drop out_valid.
- Outputs are not cleared on leaving DONE; they are meaningful only while out_valid = 1.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = IDLE, out_valid = 0, result = 0, hi = 0, zero = 0, carry = 0, overflow = 0, accumulator and counter = 0.
  - in_ready rises the first cycle after rst_n = 1.
- Single-cycle op latency: out_valid is high on the edge after the accept (1 cycle).
- MULU latency: out_valid is high WIDTH + 1 edges after the accept.
- Sustained throughput with out_ready held high: one single-cycle op per clock, and one MULU per WIDTH + 1 clocks.
- Reset mid-MUL or mid-DONE: the operation is discarded, out_valid drops immediately (asynchronous), and no stale result is ever presented.
- in_valid while in_ready = 0 has no effect; the requester holds the request.
- out_ready while out_valid = 0 has no effect.

## Test plan
- WIDTH = 8, ADD a = 0x7F, b = 0x01 → one cycle later out_valid = 1, result = 0x80, overflow = 1, carry = 0, zero = 0, hi = 0.
- SUB a = 0x05, b = 0x05 → result = 0x00, zero = 1, carry = 1, overflow = 0. Then SLT a = 0x80, b = 0x7F → result = 0x01 (overflow case). Then SLT a = 0x7F, b = 0x80 → result = 0x00.
- MULU a = 0xFF, b = 0xFF → in_ready = 0 for 8 cycles; out_valid exactly 9 cycles after accept; hi = 0xFE, result = 0x01, overflow = 1, carry = 0.
- Backpressure: ADD 0x10 + 0x20 with out_ready = 0 for 3 cycles → result = 0x30 and flags stable, in_ready = 0. On out_ready = 1, a NOR 0x0F, 0xF0 is accepted the same cycle → next cycle result = 0x00, zero = 1.
- Reset: assert rst_n = 0 four cycles into a MULU → out_valid = 0 and in_ready = 0 immediately. After release, in_ready = 1, and a following AND 0xF0 & 0x3C returns 0x30 with no stale MULU data.
- Illegal op 0101 with a = 0xFF, b = 0xFF → result = 0, zero = 1, other flags = 0, latency 1.
